md_sched: RTL

- Sequences a shared multiply/divide unit (MDU) attached to the EX stage of the 5-stage pipeline.
- Accepts issue from EX, runs a fixed-latency busy countdown and commits HI/LO at the end.
- Generates the stall request that freezes PC and IF/ID and injects a bubble into ID/EX while an MD-class instruction in ID must wait.
- The stall only drives the pipeline-register enables, which are tied to 1 today.

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_compute.sv | 57 +++++
 rtl/md_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler.
// Contents: MD operation encodings, the scheduler state enum, default busy latencies,
// and small helpers that classify an opcode.
package md_pkg;

  // MD-class operation encodings carried on e_md_op.
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  // Default busy latencies (legal range 1..15, fits the 4-bit countdown).
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Ops that occupy the MDU for a busy countdown.
  function automatic logic md_is_start_op(logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div_op(logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Purely combinational multiply/divide datapath.
// Ports:
//   op      in   4  MD operation encoding (md_pkg)
//   rs, rt  in  32  operands (rs = multiplicand / dividend, rt = multiplier / divisor)
//   res     out 64  {hi, lo}: product for MULT/MULTU, {remainder, quotient} for DIV/DIVU
//   divzero out  1  DIV/DIVU with rt == 0; res is don't-care in that case
module md_compute
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] res,
  output logic        divzero
);

  logic        sgn;
  logic        is_div;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    sgn    = (op == MD_MULT) || (op == MD_DIV);
    is_div = md_is_div_op(op);

    // Sign/zero-extend to 64 bits; the low 64 bits of the product are exact either way.
    a64  = {{32{sgn & rs[31]}}, rs};
    b64  = {{32{sgn & rt[31]}}, rt};
    prod = a64 * b64;

    // Divide on magnitudes, then restore signs. Negating 0x80000000 yields 0x80000000,
    // which as an unsigned magnitude is correct, so the overflow case falls out naturally.
    mag_a = (sgn && rs[31]) ? (32'd0 - rs) : rs;
    mag_b = (sgn && rt[31]) ? (32'd0 - rt) : rt;

    divzero = is_div && (rt == 32'd0);
    // Keep the divider away from a zero divisor; the result is discarded at commit.
    div_b   = (rt == 32'd0) ? 32'd1 : mag_b;
    q_mag   = mag_a / div_b;
    r_mag   = mag_a % div_b;

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    quot = (sgn && (rs[31] ^ rt[31])) ? (32'd0 - q_mag) : q_mag;
    rem  = (sgn && rs[31]) ? (32'd0 - r_mag) : r_mag;

    res = is_div ? {rem, quot} : prod;
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide unit sequencer for the EX stage.
// Accepts MULT/MULTU/DIV/DIVU issue from EX while idle, latches the combinational result,
// counts down a fixed latency and commits HI/LO at the end. MTHI/MTLO write HI/LO directly
// when idle. Produces the stall request that holds an MD-class instruction in ID.
// Optional feature macro: MD_PERF_CNT_EN adds stall_cnt and md_ops performance counters.
// Ports:
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   e_md_valid  in   1  EX-stage instruction is MD-class
//   e_md_op     in   4  MD operation (md_pkg encodings)
//   e_rs, e_rt  in  32  forwarded EX operands
//   d_md_use    in   1  ID-stage instruction is MD-class
//   busy        out  1  MDU computing
//   stall       out  1  pipeline stall request (combinational)
//   hi, lo      out 32  HI/LO registers
//   done        out  1  one-cycle pulse following the HI/LO commit edge
//   stall_cnt   out 32  (MD_PERF_CNT_EN) saturating count of stall cycles
//   md_ops      out 16  (MD_PERF_CNT_EN) wrapping count of accepted starts
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_md_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
`ifdef MD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] md_ops
`endif
);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic [63:0] res_q;
  logic        divz_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [63:0] comp_res;
  logic        comp_divzero;
  logic        start;

  md_compute u_compute (
    .op      (e_md_op),
    .rs      (e_rs),
    .rt      (e_rt),
    .res     (comp_res),
    .divzero (comp_divzero)
  );

  always_comb begin
    start = (state_q == IDLE) && e_md_valid && md_is_start_op(e_md_op);
    // Holds an MD op in ID while the unit is occupied or is being claimed this cycle.
    stall = d_md_use && (start || busy_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      divz_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            res_q   <= comp_res;
            divz_q  <= comp_divzero;
            cnt_q   <= md_is_div_op(e_md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end else if (e_md_valid && (e_md_op == MD_MTHI)) begin
            hi_q <= e_rs;
          end else if (e_md_valid && (e_md_op == MD_MTLO)) begin
            lo_q <= e_rs;
          end
        end
        BUSY: begin
          // Any issue arriving here is an illegal stream and is ignored.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (!divz_q) begin
              hi_q <= res_q[63:32];
              lo_q <= res_q[31:0];
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifdef MD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] md_ops_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      md_ops_q    <= 16'd0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (start) begin
        md_ops_q <= md_ops_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign md_ops    = md_ops_q;
`endif

endmodule
